// File: rtl/clint_timer_if.sv
// Request/valid bus shared by the core data port and the CLINT slave.
// Handshake: read_enable/write_enable are one-cycle requests sampled at every rising edge;
// each sampled request gets exactly one response pulse (read_valid or write_ready) after the next edge.
interface clint_timer_if;
  logic [31:0] address;
  logic        read_enable;
  logic [31:0] read_data;
  logic        read_valid;
  logic [31:0] write_data;
  logic        write_enable;
  logic [3:0]  write_wstrb;
  logic        write_ready;

  modport master (
    output address, read_enable, write_data, write_enable, write_wstrb,
    input  read_data, read_valid, write_ready
  );

  modport slave (
    input  address, read_enable, write_data, write_enable, write_wstrb,
    output read_data, read_valid, write_ready
  );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp and msip behind a memory-mapped slave,
// driving registered machine timer and software interrupt lines.
module clint_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  clint_timer_if.slave bus,
  output logic         timer_int,
  output logic         soft_int
);

  localparam logic [13:0] OFF_MSIP    = 14'h0000;
  localparam logic [13:0] OFF_CMP_LO  = 14'h1000;
  localparam logic [13:0] OFF_CMP_HI  = 14'h1001;
  localparam logic [13:0] OFF_TIME_LO = 14'h2FFE;
  localparam logic [13:0] OFF_TIME_HI = 14'h2FFF;
  localparam logic [15:0] PRESC_MAX   = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [31:0] read_data_q, read_data_d;
  logic        read_valid_q, read_valid_d;
  logic        wr_pend_q, wr_pend_d;
  logic        write_ready_q, write_ready_d;
  logic        timer_int_q, timer_int_d;
  logic        soft_int_q, soft_int_d;

  logic [13:0] word;
  logic [31:0] rd_word;
  logic [31:0] merged;
  logic        tick;
  logic        addr_unused;

  assign addr_unused = ^{bus.address[31:16], bus.address[1:0]};

  always_comb begin
    word    = bus.address[15:2];
    rd_word = '0;
    case (word)
      OFF_MSIP:    rd_word = {31'b0, msip_q};
      OFF_CMP_LO:  rd_word = mtimecmp_q[31:0];
      OFF_CMP_HI:  rd_word = mtimecmp_q[63:32];
      OFF_TIME_LO: rd_word = mtime_q[31:0];
      OFF_TIME_HI: rd_word = mtime_q[63:32];
      default:     rd_word = '0;
    endcase

    // Byte-merge against the current word; irrelevant for unmapped offsets since the result is dropped.
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (bus.write_wstrb[i]) merged[8*i +: 8] = bus.write_data[8*i +: 8];
    end

    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = mtime_q + {63'b0, tick};
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;

    // An mtime write replaces this cycle's increment; the other word keeps its old value, no carry.
    if (bus.write_enable) begin
      case (word)
        OFF_MSIP:    msip_d            = merged[0];
        OFF_CMP_LO:  mtimecmp_d[31:0]  = merged;
        OFF_CMP_HI:  mtimecmp_d[63:32] = merged;
        OFF_TIME_LO: mtime_d           = {mtime_q[63:32], merged};
        OFF_TIME_HI: mtime_d           = {merged, mtime_q[31:0]};
        default:     ;
      endcase
    end

    rd_pend_d     = bus.read_enable;
    rd_buf_d      = bus.read_enable ? rd_word : rd_buf_q;
    read_valid_d  = rd_pend_q;
    read_data_d   = rd_pend_q ? rd_buf_q : read_data_q;
    wr_pend_d     = bus.write_enable;
    write_ready_d = wr_pend_q;
    timer_int_d   = (mtime_q >= mtimecmp_q);
    soft_int_d    = msip_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q       <= '0;
      mtime_q       <= '0;
      mtimecmp_q    <= '1;
      msip_q        <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_buf_q      <= '0;
      read_data_q   <= '0;
      read_valid_q  <= 1'b0;
      wr_pend_q     <= 1'b0;
      write_ready_q <= 1'b0;
      timer_int_q   <= 1'b0;
      soft_int_q    <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      mtime_q       <= mtime_d;
      mtimecmp_q    <= mtimecmp_d;
      msip_q        <= msip_d;
      rd_pend_q     <= rd_pend_d;
      rd_buf_q      <= rd_buf_d;
      read_data_q   <= read_data_d;
      read_valid_q  <= read_valid_d;
      wr_pend_q     <= wr_pend_d;
      write_ready_q <= write_ready_d;
      timer_int_q   <= timer_int_d;
      soft_int_q    <= soft_int_d;
    end
  end

  assign bus.read_data   = read_data_q;
  assign bus.read_valid  = read_valid_q;
  assign bus.write_ready = write_ready_q;
  assign timer_int       = timer_int_q;
  assign soft_int        = soft_int_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed corner steps plus random bus traffic, checked every cycle
// against a register-level model of the timer block.
module tb_clint_timer;

  localparam int PRESC = 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  clint_timer_if bus ();
  clint_timer_if bus4 ();
  logic timer_int, soft_int, timer_int4, soft_int4;

  clint_timer #(.PRESCALE(PRESC)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .timer_int(timer_int), .soft_int(soft_int)
  );

  clint_timer #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4), .timer_int(timer_int4), .soft_int(soft_int4)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip;
  int          edge_n;
  logic        m_rd_pend, m_wr_pend;
  logic [31:0] m_rdata;
  logic [31:0] exp_q[$];
  logic        e_rv, e_wr, e_ti, e_si;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_word(input logic [15:0] off);
    case (off)
      16'h0000: return {31'b0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mtime[31:0];
      16'hBFFC: return m_mtime[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtime = '0; m_cmp = '1; m_msip = 1'b0; edge_n = 0;
    m_rd_pend = 1'b0; m_wr_pend = 1'b0; m_rdata = '0;
    exp_q.delete();
    e_rv = 1'b0; e_wr = 1'b0; e_ti = 1'b0; e_si = 1'b0;
  endtask

  task automatic model_edge();
    logic [63:0] old_t;
    logic [15:0] off;
    logic [31:0] cur, merged;
    old_t = m_mtime;
    off   = {bus.address[15:2], 2'b00};
    e_rv  = m_rd_pend;
    e_wr  = m_wr_pend;
    e_ti  = (m_mtime >= m_cmp);
    e_si  = m_msip;
    if (m_rd_pend) m_rdata = exp_q.pop_front();
    m_rd_pend = bus.read_enable;
    m_wr_pend = bus.write_enable;
    cur = m_word(off);
    if (bus.read_enable) exp_q.push_back(cur);
    edge_n++;
    if (edge_n % PRESC == 0) m_mtime = old_t + 64'd1;
    if (bus.write_enable) begin
      for (int i = 0; i < 4; i++)
        merged[8*i +: 8] = bus.write_wstrb[i] ? bus.write_data[8*i +: 8] : cur[8*i +: 8];
      case (off)
        16'h0000: m_msip = merged[0];
        16'h4000: m_cmp[31:0] = merged;
        16'h4004: m_cmp[63:32] = merged;
        16'hBFF8: m_mtime = {old_t[63:32], merged};
        16'hBFFC: m_mtime = {merged, old_t[31:0]};
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("read_valid", bus.read_valid, e_rv);
    chk("read_data", bus.read_data, m_rdata);
    chk("write_ready", bus.write_ready, e_wr);
    chk("timer_int", timer_int, e_ti);
    chk("soft_int", soft_int, e_si);
  endtask

  task automatic idle();
    bus.read_enable = 1'b0; bus.write_enable = 1'b0; bus.write_wstrb = 4'h0;
    bus.address = '0; bus.write_data = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic reset_now();
    reset_n = 1'b0;
    idle();
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus.address = addr; bus.write_data = data; bus.write_wstrb = strb; bus.write_enable = 1'b1;
    cycle();
    idle();
  endtask

  task automatic expect_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.address = addr; bus.read_enable = 1'b1;
    cycle();
    idle();
    cycle();
    chk({tag, "_valid"}, bus.read_valid, 1'b1);
    chk(tag, bus.read_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp4;
    logic [31:0] addrs [6];
    bus4.address = 32'h0; bus4.read_enable = 1'b0; bus4.write_enable = 1'b0;
    bus4.write_data = 32'h0; bus4.write_wstrb = 4'h0;
    reset_now();

    // Reset values
    expect_read("rst_msip", 32'h0000_0000, 32'h0);
    expect_read("rst_cmp_lo", 32'h0000_4000, 32'hFFFF_FFFF);
    expect_read("rst_cmp_hi", 32'h0000_4004, 32'hFFFF_FFFF);
    bus.address = 32'hBFF8; bus.read_enable = 1'b1; cycle(); idle(); cycle();
    bus.address = 32'hBFFC; bus.read_enable = 1'b1; cycle(); idle(); cycle();

    // PRESCALE=4 instance: mtime after 40 edges
    while (edge_n < 39) cycle();
    bus4.address = 32'hBFF8; bus4.read_enable = 1'b1;
    cycle();
    exp4 = 32'((edge_n - 1) / 4);
    bus4.read_enable = 1'b0;
    cycle();
    chk("presc4_valid", bus4.read_valid, 1'b1);
    chk("presc4_mtime", bus4.read_data, exp4);
    chk("presc4_lo_is_9", bus4.read_data, 32'd9);
    chk("presc4_timer", timer_int4, 1'b0);

    // Timer fire and clear
    reset_now();
    wr(32'h4004, 32'h0, 4'hF);
    wr(32'h4000, 32'd20, 4'hF);
    repeat (25) cycle();
    chk("timer_fired", timer_int, 1'b1);
    wr(32'h4000, 32'hFFFF_FFFF, 4'hF);
    wr(32'h4004, 32'hFFFF_FFFF, 4'hF);
    repeat (5) cycle();
    chk("timer_cleared", timer_int, 1'b0);

    // Carry and write override
    wr(32'hBFF8, 32'hFFFF_FFFE, 4'hF);
    wr(32'hBFFC, 32'h0, 4'hF);
    repeat (3) cycle();
    wr(32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    repeat (4) cycle();

    // Software interrupt and byte strobes
    wr(32'h0, 32'h1, 4'b0001);
    cycle();
    chk("soft_set", soft_int, 1'b1);
    wr(32'h0, 32'h0, 4'b0000);
    chk("wstrb0_ready", bus.write_ready, 1'b0);
    cycle();
    chk("wstrb0_ready_pulse", bus.write_ready, 1'b1);
    chk("soft_hold", soft_int, 1'b1);
    wr(32'h0, 32'h0, 4'hF);
    repeat (2) cycle();
    chk("soft_clr", soft_int, 1'b0);
    wr(32'h4000, 32'hAABB_CCDD, 4'b0101);
    expect_read("wstrb_merge", 32'h4000, 32'hFFBB_FFDD);

    // Bus corners
    expect_read("unmapped", 32'h1234, 32'h0);
    bus.address = 32'h0; bus.write_data = 32'h1; bus.write_wstrb = 4'hF;
    bus.write_enable = 1'b1; bus.read_enable = 1'b1;
    cycle();
    idle();
    cycle();
    chk("rw_old_valid", bus.read_valid, 1'b1);
    chk("rw_old", bus.read_data, 32'h0);
    bus.read_enable = 1'b1; bus.address = 32'h0;    cycle();
    bus.address = 32'h4000;                          cycle();
    chk("b2b_valid1", bus.read_valid, 1'b1);
    bus.address = 32'h4004;                          cycle();
    chk("b2b_valid2", bus.read_valid, 1'b1);
    idle();                                          cycle();
    chk("b2b_valid3", bus.read_valid, 1'b1);
    cycle();
    chk("b2b_end", bus.read_valid, 1'b0);

    // Reset during pending read
    bus.address = 32'h0; bus.read_enable = 1'b1;
    cycle();
    reset_now();
    cycle();
    chk("rst_drop_valid", bus.read_valid, 1'b0);
    cycle();

    // Random traffic
    addrs[0] = 32'h0000; addrs[1] = 32'h4000; addrs[2] = 32'h4004;
    addrs[3] = 32'hBFF8; addrs[4] = 32'hBFFC; addrs[5] = 32'h0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom() : addrs[$urandom_range(0, 4)];
      a[1:0] = 2'($urandom_range(0, 3));
      bus.address      = a;
      bus.read_enable  = 1'($urandom_range(0, 1));
      bus.write_enable = ($urandom_range(0, 2) == 0);
      bus.write_wstrb  = 4'($urandom_range(0, 15));
      bus.write_data   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 80)) : $urandom();
      cycle();
    end
    idle();
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
